// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, aluop encodings, funct3 values and the issue FSM states.
// Imported by the ALU, the control decoder and the issue sequencer so all agree on one encoding.
package alu_pkg;

   localparam int ALU_XLEN   = 64;
   localparam int ALU_CTRL_W = 4;

   typedef logic [ALU_CTRL_W-1:0] ctrl_t;

   localparam ctrl_t CTRL_AND  = 4'b0000;
   localparam ctrl_t CTRL_OR   = 4'b0001;
   localparam ctrl_t CTRL_ADD  = 4'b0010;
   localparam ctrl_t CTRL_XOR  = 4'b0011;
   localparam ctrl_t CTRL_SLL  = 4'b0100;
   localparam ctrl_t CTRL_SRL  = 4'b0101;
   localparam ctrl_t CTRL_SUB  = 4'b0110;
   localparam ctrl_t CTRL_SRA  = 4'b0111;
   localparam ctrl_t CTRL_SLT  = 4'b1000;
   localparam ctrl_t CTRL_SLTU = 4'b1001;

   localparam logic [1:0] ALUOP_MEM = 2'b00;
   localparam logic [1:0] ALUOP_BR  = 2'b01;
   localparam logic [1:0] ALUOP_R   = 2'b10;
   localparam logic [1:0] ALUOP_I   = 2'b11;

   localparam logic [2:0] F3_ADDSUB = 3'b000;
   localparam logic [2:0] F3_SLL    = 3'b001;
   localparam logic [2:0] F3_SLT    = 3'b010;
   localparam logic [2:0] F3_SLTU   = 3'b011;
   localparam logic [2:0] F3_XOR    = 3'b100;
   localparam logic [2:0] F3_SR     = 3'b101;
   localparam logic [2:0] F3_OR     = 3'b110;
   localparam logic [2:0] F3_AND    = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_HOLD = 2'b10
   } state_e;

   // Only the adder produces meaningful carry/overflow; other ops must report 0.
   function automatic logic ctrl_sets_flags(input ctrl_t c);
      return (c == CTRL_ADD) || (c == CTRL_SUB);
   endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational ALU control decode: (aluop, funct3, funct7[5]) -> 4-bit control and illegal flag.
// Zero latency, no handshake; shared with the decode stage.
module alu_ctrl_dec
   import alu_pkg::*;
(
   input  logic [1:0] i_aluop,
   input  logic [2:0] i_funct3,
   input  logic       i_funct7b5,
   output ctrl_t      o_control,
   output logic       o_illegal
);

   logic w_is_rtype;

   assign w_is_rtype = (i_aluop == ALUOP_R);

   always_comb begin
      o_control = CTRL_ADD;
      case (i_aluop)
         ALUOP_MEM: o_control = CTRL_ADD;
         ALUOP_BR:  o_control = CTRL_SUB;
         ALUOP_R,
         ALUOP_I: begin
            // I-type has no SUB; bit 30 there only distinguishes SRA from SRL.
            case (i_funct3)
               F3_ADDSUB: o_control = (w_is_rtype && i_funct7b5) ? CTRL_SUB : CTRL_ADD;
               F3_SLL:    o_control = CTRL_SLL;
               F3_SLT:    o_control = CTRL_SLT;
               F3_SLTU:   o_control = CTRL_SLTU;
               F3_XOR:    o_control = CTRL_XOR;
               F3_SR:     o_control = i_funct7b5 ? CTRL_SRA : CTRL_SRL;
               F3_OR:     o_control = CTRL_OR;
               F3_AND:    o_control = CTRL_AND;
            endcase
         end
      endcase
   end

   assign o_illegal = w_is_rtype && i_funct7b5 &&
                      (i_funct3 != F3_ADDSUB) && (i_funct3 != F3_SR);

endmodule

// File: rtl/alu_issue_seq.sv
// Execute front end: latch op, drive ALU for one settle cycle, register result+flags; accept->out_valid 2 cycles.
// Result held in HOLD until out_ready; a new op is accepted in the same cycle the result is consumed.
module alu_issue_seq
   import alu_pkg::*;
#(
   parameter int XLEN   = ALU_XLEN,
   parameter int CTRL_W = ALU_CTRL_W
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_aluop,
   input  logic [2:0]        in_funct3,
   input  logic              in_funct7b5,
   input  logic [XLEN-1:0]   in_rs1,
   input  logic [XLEN-1:0]   in_rs2,
   output logic [XLEN-1:0]   alu_rs1,
   output logic [XLEN-1:0]   alu_rs2,
   output logic [CTRL_W-1:0] alu_control,
   input  logic [XLEN-1:0]   alu_rd,
   input  logic              alu_carry,
   input  logic              alu_overflow,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_result,
   output logic              out_zero,
   output logic              out_carry,
   output logic              out_overflow,
   output logic              out_illegal
);

   state_e            r_state;
   logic [XLEN-1:0]   r_rs1;
   logic [XLEN-1:0]   r_rs2;
   logic [CTRL_W-1:0] r_ctrl;
   logic              r_illegal;
   logic [XLEN-1:0]   r_result;
   logic              r_zero;
   logic              r_carry;
   logic              r_ovf;
   logic              r_out_illegal;

   ctrl_t             w_dec_ctrl;
   logic              w_dec_illegal;
   logic              w_accept;
   logic              w_flags_ok;

   alu_ctrl_dec u_dec (
      .i_aluop    (in_aluop),
      .i_funct3   (in_funct3),
      .i_funct7b5 (in_funct7b5),
      .o_control  (w_dec_ctrl),
      .o_illegal  (w_dec_illegal)
   );

   // HOLD frees up combinationally on out_ready so back-to-back ops issue every 2 cycles.
   assign in_ready  = !rst && ((r_state == ST_IDLE) ||
                               ((r_state == ST_HOLD) && out_ready));
   assign w_accept  = in_valid && in_ready;
   assign w_flags_ok = !r_illegal && ctrl_sets_flags(r_ctrl);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_rs1         <= '0;
         r_rs2         <= '0;
         r_ctrl        <= '0;
         r_illegal     <= 1'b0;
         r_result      <= '0;
         r_zero        <= 1'b0;
         r_carry       <= 1'b0;
         r_ovf         <= 1'b0;
         r_out_illegal <= 1'b0;
      end else begin
         if (w_accept) begin
            r_rs1     <= in_rs1;
            r_rs2     <= in_rs2;
            r_ctrl    <= w_dec_ctrl;
            r_illegal <= w_dec_illegal;
         end
         case (r_state)
            ST_IDLE: begin
               if (w_accept) r_state <= ST_EXEC;
            end
            ST_EXEC: begin
               // Illegal ops report a clean zero result regardless of what the ALU computed.
               r_result      <= r_illegal ? '0 : alu_rd;
               r_zero        <= r_illegal ? 1'b1 : (alu_rd == '0);
               r_carry       <= w_flags_ok & alu_carry;
               r_ovf         <= w_flags_ok & alu_overflow;
               r_out_illegal <= r_illegal;
               r_state       <= ST_HOLD;
            end
            ST_HOLD: begin
               if (out_ready) r_state <= w_accept ? ST_EXEC : ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign alu_rs1      = r_rs1;
   assign alu_rs2      = r_rs2;
   assign alu_control  = r_ctrl;

   assign out_valid    = (r_state == ST_HOLD);
   assign out_result   = r_result;
   assign out_zero     = r_zero;
   assign out_carry    = r_carry;
   assign out_overflow = r_ovf;
   assign out_illegal  = r_out_illegal;

endmodule

// File: tb/tb_alu_issue_seq.sv
// Scoreboard bench for alu_issue_seq: behavioural ALU on the alu_* side, op-level reference model,
// directed cases followed by randomized traffic with random output backpressure.
module tb_alu_issue_seq;
   import alu_pkg::*;

   typedef enum int {K_ADD, K_SUB, K_SLL, K_SLT, K_SLTU, K_XOR, K_SRL, K_SRA, K_OR, K_AND} kind_e;

   typedef struct {
      logic [63:0] res;
      logic        zero;
      logic        carry;
      logic        ovf;
      logic        ill;
      logic [3:0]  ctrl;
      logic [63:0] a;
      logic [63:0] b;
      int          acc_cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  in_aluop = 2'b00;
   logic [2:0]  in_funct3 = 3'b000;
   logic        in_funct7b5 = 1'b0;
   logic [63:0] in_rs1 = 64'd0;
   logic [63:0] in_rs2 = 64'd0;
   logic [63:0] alu_rs1;
   logic [63:0] alu_rs2;
   logic [3:0]  alu_control;
   logic [63:0] alu_rd;
   logic        alu_carry;
   logic        alu_overflow;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [63:0] out_result;
   logic        out_zero;
   logic        out_carry;
   logic        out_overflow;
   logic        out_illegal;

   int   n_checks = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   acc_cnt = 0;
   int   b2b_cnt = 0;
   int   exec_due = -1;
   bit   popped = 1'b0;
   bit   rdy_force_low = 1'b0;
   bit   rdy_rand = 1'b0;
   exp_t sb_q[$];
   exp_t cur;
   exp_t exec_exp;
   logic [67:0] snap;
   logic [64:0] alu_sum;
   logic [63:0] alu_b_eff;

   alu_issue_seq #(.XLEN(64), .CTRL_W(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_aluop(in_aluop), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
      .in_rs1(in_rs1), .in_rs2(in_rs2),
      .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_control(alu_control),
      .alu_rd(alu_rd), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_zero(out_zero), .out_carry(out_carry),
      .out_overflow(out_overflow), .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;

   // Combinational ALU; adder flags are exposed for every op so forcing to 0 is observable.
   always_comb begin
      alu_b_eff    = (alu_control == CTRL_SUB) ? ~alu_rs2 : alu_rs2;
      alu_sum      = {1'b0, alu_rs1} + {1'b0, alu_b_eff} + {64'd0, alu_control == CTRL_SUB};
      alu_carry    = alu_sum[64];
      alu_overflow = (alu_rs1[63] == alu_b_eff[63]) && (alu_sum[63] != alu_rs1[63]);
      alu_rd       = 64'd0;
      case (alu_control)
         CTRL_AND:  alu_rd = alu_rs1 & alu_rs2;
         CTRL_OR:   alu_rd = alu_rs1 | alu_rs2;
         CTRL_ADD:  alu_rd = alu_sum[63:0];
         CTRL_XOR:  alu_rd = alu_rs1 ^ alu_rs2;
         CTRL_SLL:  alu_rd = alu_rs1 << alu_rs2[5:0];
         CTRL_SRL:  alu_rd = alu_rs1 >> alu_rs2[5:0];
         CTRL_SUB:  alu_rd = alu_sum[63:0];
         CTRL_SRA:  alu_rd = $signed(alu_rs1) >>> alu_rs2[5:0];
         CTRL_SLT:  alu_rd = {63'd0, $signed(alu_rs1) < $signed(alu_rs2)};
         CTRL_SLTU: alu_rd = {63'd0, alu_rs1 < alu_rs2};
         default:   alu_rd = 64'd0;
      endcase
   end

   function automatic exp_t ref_model(input logic [1:0] op, input logic [2:0] f3,
                                      input logic b5, input logic [63:0] a, input logic [63:0] b);
      exp_t e;
      kind_e k;
      logic [64:0] wide;
      e.a = a; e.b = b; e.carry = 1'b0; e.ovf = 1'b0; e.acc_cyc = 0;
      e.ill = (op == 2'b10) && b5 && (f3 != 3'd0) && (f3 != 3'd5);
      if (op == 2'b00) k = K_ADD;
      else if (op == 2'b01) k = K_SUB;
      else begin
         case (f3)
            3'd0: k = (op == 2'b10 && b5) ? K_SUB : K_ADD;
            3'd1: k = K_SLL;
            3'd2: k = K_SLT;
            3'd3: k = K_SLTU;
            3'd4: k = K_XOR;
            3'd5: k = b5 ? K_SRA : K_SRL;
            3'd6: k = K_OR;
            default: k = K_AND;
         endcase
      end
      case (k)
         K_ADD: begin
            e.res = a + b; e.ctrl = 4'b0010; e.carry = (e.res < a);
            wide = {a[63], a} + {b[63], b}; e.ovf = wide[64] ^ wide[63];
         end
         K_SUB: begin
            e.res = a - b; e.ctrl = 4'b0110; e.carry = (a >= b);
            wide = {a[63], a} - {b[63], b}; e.ovf = wide[64] ^ wide[63];
         end
         K_SLL:  begin e.res = a << b[5:0]; e.ctrl = 4'b0100; end
         K_SRL:  begin e.res = a >> b[5:0]; e.ctrl = 4'b0101; end
         K_SRA:  begin e.res = $signed(a) >>> b[5:0]; e.ctrl = 4'b0111; end
         K_SLT:  begin e.res = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0; e.ctrl = 4'b1000; end
         K_SLTU: begin e.res = (a < b) ? 64'd1 : 64'd0; e.ctrl = 4'b1001; end
         K_XOR:  begin e.res = a ^ b; e.ctrl = 4'b0011; end
         K_OR:   begin e.res = a | b; e.ctrl = 4'b0001; end
         default: begin e.res = a & b; e.ctrl = 4'b0000; end
      endcase
      if (e.ill) begin e.res = 64'd0; e.carry = 1'b0; e.ovf = 1'b0; end
      e.zero = (e.res == 64'd0);
      return e;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor + scoreboard; all sampling at negedge where every input and output is settled.
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         sb_q.delete();
         popped = 1'b0;
         exec_due = -1;
      end else begin
         if (cyc == exec_due) begin
            chk("exec_alu_control", alu_control, exec_exp.ctrl);
            chk("exec_alu_rs1", alu_rs1, exec_exp.a);
            chk("exec_alu_rs2", alu_rs2, exec_exp.b);
         end
         if (out_valid) begin
            if (!popped) begin
               if (sb_q.size() == 0) begin
                  n_checks++; n_fail++;
                  $display("FAIL unexpected_out_valid: got result 0x%0h, expected no output", out_result);
               end else begin
                  cur = sb_q.pop_front();
                  chk("latency", cyc - cur.acc_cyc, 2);
                  chk("result", out_result, cur.res);
                  chk("zero", out_zero, cur.zero);
                  chk("carry", out_carry, cur.carry);
                  chk("overflow", out_overflow, cur.ovf);
                  chk("illegal", out_illegal, cur.ill);
               end
               popped = 1'b1;
               snap = {out_result, out_zero, out_carry, out_overflow, out_illegal};
            end else begin
               chk("hold_stable", {out_result, out_zero, out_carry, out_overflow, out_illegal}, snap);
            end
            if (out_ready) popped = 1'b0;
         end
         if (in_valid && in_ready) begin
            exec_exp = ref_model(in_aluop, in_funct3, in_funct7b5, in_rs1, in_rs2);
            exec_exp.acc_cyc = cyc;
            sb_q.push_back(exec_exp);
            exec_due = cyc + 1;
            acc_cnt++;
            if (out_valid && out_ready) b2b_cnt++;
         end
      end
   end

   always @(posedge clk) begin
      #1;
      out_ready = rdy_force_low ? 1'b0 : (rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1);
   end

   task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic b5,
                        input logic [63:0] a, input logic [63:0] b);
      int start;
      int t;
      @(posedge clk); #1;
      in_valid = 1'b1; in_aluop = op; in_funct3 = f3; in_funct7b5 = b5;
      in_rs1 = a; in_rs2 = b;
      start = acc_cnt; t = 0;
      while (acc_cnt == start && t < 200) begin @(negedge clk); t++; end
      if (acc_cnt == start) begin
         n_checks++; n_fail++;
         $display("FAIL issue_timeout: got no accept in %0d cycles, expected accept", t);
      end
   endtask

   task automatic go_idle();
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_aluop = 2'($urandom); in_funct3 = 3'($urandom); in_funct7b5 = 1'($urandom);
      in_rs1 = {$urandom, $urandom}; in_rs2 = {$urandom, $urandom};
   endtask

   function automatic logic [63:0] rnd_opnd();
      case ($urandom_range(0, 5))
         0: return 64'd0;
         1: return 64'hFFFF_FFFF_FFFF_FFFF;
         2: return 64'h7FFF_FFFF_FFFF_FFFF;
         3: return 64'h8000_0000_0000_0000;
         4: return 64'($urandom_range(0, 70));
         default: return {$urandom, $urandom};
      endcase
   endfunction

   task automatic drain();
      int t;
      t = 0;
      while ((sb_q.size() != 0 || out_valid) && t < 300) begin @(negedge clk); t++; end
      if (sb_q.size() != 0) begin
         n_checks++; n_fail++;
         $display("FAIL drain_timeout: got %0d outstanding results, expected 0", sb_q.size());
      end
   endtask

   initial begin
      int t;
      int b2b_before;
      // Reset with an op offered: nothing may be accepted and all outputs are cleared.
      rst = 1'b1; in_valid = 1'b1; in_rs1 = 64'hDEAD; in_rs2 = 64'hBEEF;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_result", out_result, 0);
      chk("rst_out_zero", out_zero, 0);
      chk("rst_out_carry", out_carry, 0);
      chk("rst_out_overflow", out_overflow, 0);
      chk("rst_out_illegal", out_illegal, 0);
      chk("rst_alu_control", alu_control, 0);
      chk("rst_alu_rs1", alu_rs1, 0);
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("idle_in_ready", in_ready, 1);

      issue(2'b10, 3'd0, 1'b0, 64'd5, 64'd7);
      issue(2'b01, 3'd0, 1'b0, 64'h10, 64'h10);
      issue(2'b00, 3'd0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
      go_idle();
      drain();

      // Stall in HOLD, then release with a new op waiting.
      rdy_force_low = 1'b1;
      issue(2'b00, 3'd0, 1'b0, 64'd100, 64'd23);
      go_idle();
      t = 0;
      while (!out_valid && t < 10) begin @(negedge clk); t++; end
      repeat (5) begin
         @(negedge clk);
         chk("stall_out_valid", out_valid, 1);
         chk("stall_in_ready", in_ready, 0);
      end
      b2b_before = b2b_cnt;
      rdy_force_low = 1'b0;
      issue(2'b10, 3'd4, 1'b0, 64'hF0F0, 64'h0FF0);
      chk("back_to_back_accept", b2b_cnt - b2b_before, 1);
      go_idle();
      drain();

      issue(2'b11, 3'd0, 1'b1, 64'd9, 64'd4);
      issue(2'b11, 3'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 64'd2);
      issue(2'b10, 3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
      issue(2'b10, 3'd6, 1'b1, 64'h1234, 64'h5678);
      issue(2'b10, 3'd1, 1'b0, 64'h1, 64'd63);
      go_idle();
      drain();

      rdy_rand = 1'b1;
      for (int i = 0; i < 250; i++) begin
         issue(2'($urandom), 3'($urandom), 1'($urandom), rnd_opnd(), rnd_opnd());
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) go_idle();
      end
      go_idle();
      rdy_rand = 1'b0;
      drain();

      // Reset while the op is in EXEC: it must vanish without an out_valid pulse.
      issue(2'b00, 3'd0, 1'b0, 64'd40, 64'd2);
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_out_result", out_result, 0);
      chk("midrst_in_ready", in_ready, 0);
      chk("midrst_alu_control", alu_control, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("postrst_no_valid", out_valid, 0);
      end
      issue(2'b10, 3'd7, 1'b0, 64'hFF00, 64'h0FF0);
      go_idle();
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish by 200000, expected finish");
      $fatal(1, "timeout");
   end

endmodule
